// File: rtl/led_status_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_status_pkg
// Description : Shared constants and helpers for the LED status controller.
//               Holds the per-channel mode encoding and the counter width
//               helper used by the tick generator and the channel logic.
// Revision    : 1.0 - initial release
// ============================================================================
package led_status_pkg;

    // Per-channel mode codes. Codes 5..7 are reserved and behave as OFF.
    localparam logic [2:0] MODE_OFF      = 3'd0;
    localparam logic [2:0] MODE_ON       = 3'd1;
    localparam logic [2:0] MODE_BLINK    = 3'd2;
    localparam logic [2:0] MODE_ACTIVITY = 3'd3;
    localparam logic [2:0] MODE_LINK_ACT = 3'd4;

    // Bits needed for a counter holding 0..num_values-1, never less than 1.
    function automatic int cnt_width(input int num_values);
        return (num_values <= 2) ? 1 : $clog2(num_values);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_tick_gen
// Description : Free-running tick divider shared by all LED channels.
//               Emits a one-cycle tick every TICK_CYCLES clocks; the first
//               tick after reset release appears TICK_CYCLES cycles later.
// Ports       : clk    - clock
//               rst    - synchronous active-high reset
//               tick_o - registered one-cycle tick strobe
// Revision    : 1.0 - initial release
// ============================================================================
module led_tick_gen
    import led_status_pkg::*;
#(
    parameter int TICK_CYCLES = 25000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int              c_cnt_w = cnt_width(TICK_CYCLES);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_CYCLES - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_tick;

    // The strobe is registered, so it is high in the cycle after the counter
    // sat at its last value; this keeps tick_o glitch-free and low in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == c_last) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + c_cnt_w'(1);
            r_tick <= 1'b0;
        end
    end

    assign tick_o = r_tick;

endmodule
`default_nettype wire

// File: rtl/led_status_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_status_ctrl
// Description : Multi-channel status LED driver. Each channel runs OFF, ON,
//               BLINK, ACTIVITY (pulse stretch) or LINK_ACT from one shared
//               tick. Outputs are registered and optionally inverted.
// Ports       : clk      - clock
//               rst      - synchronous active-high reset
//               mode     - 3 bits per channel, channel n at [3n+2:3n]
//               rate_sel - 2 bits per channel, blink half-period select
//               event_i  - activity strobe per channel
//               link_i   - link-up level per channel
//               led_o    - registered LED drive (XOR ACTIVE_LOW)
//               tick_o   - shared tick strobe
// Revision    : 1.0 - initial release
// ============================================================================
module led_status_ctrl
    import led_status_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int TICK_CYCLES   = 25000,
    parameter int BLINK_BASE    = 64,
    parameter int STRETCH_TICKS = 50,
    parameter int ACT_HALF      = 32,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3*CHANNELS-1:0] mode,
    input  logic [2*CHANNELS-1:0] rate_sel,
    input  logic [CHANNELS-1:0]   event_i,
    input  logic [CHANNELS-1:0]   link_i,
    output logic [CHANNELS-1:0]   led_o,
    output logic                  tick_o
);

    localparam int c_pcnt_w = cnt_width(BLINK_BASE << 3);
    localparam int c_str_w  = cnt_width(STRETCH_TICKS + 1);
    localparam logic [c_str_w-1:0] c_str_load = c_str_w'(STRETCH_TICKS);
    localparam logic [31:0]        c_act_half = 32'(ACT_HALF);

    logic w_tick;

    led_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .tick_o (w_tick)
    );

    assign tick_o = w_tick;

    for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
        logic [2:0]          r_mode;
        logic [c_pcnt_w-1:0] r_pcnt;
        logic                r_phase;
        logic [c_str_w-1:0]  r_stretch;
        logic                r_led;

        logic [2:0]          w_mode;
        logic [1:0]          w_rate;
        logic [31:0]         w_blink_half;
        logic [c_pcnt_w-1:0] w_pcnt;
        logic                w_phase;
        logic [c_str_w-1:0]  w_stretch;
        logic                w_led;

        assign w_mode       = mode[3*n +: 3];
        assign w_rate       = rate_sel[2*n +: 2];
        assign w_blink_half = 32'(BLINK_BASE) << w_rate;

        always_comb begin
            w_pcnt    = r_pcnt;
            w_phase   = r_phase;
            w_stretch = r_stretch;
            w_led     = 1'b0;

            if (w_mode != r_mode) begin
                // Entering a new mode always starts from a clean slate.
                w_pcnt    = '0;
                w_phase   = 1'b0;
                w_stretch = '0;
            end else begin
                case (r_mode)
                    MODE_BLINK: begin
                        // ">=" rather than "==" so a shorter rate picked
                        // mid-count toggles on the next tick instead of
                        // running the counter round.
                        if (w_tick) begin
                            if (32'(r_pcnt) + 32'd1 >= w_blink_half) begin
                                w_pcnt  = '0;
                                w_phase = ~r_phase;
                            end else begin
                                w_pcnt = r_pcnt + c_pcnt_w'(1);
                            end
                        end
                    end
                    MODE_ACTIVITY, MODE_LINK_ACT: begin
                        // An event reload beats a coincident tick decrement.
                        if (event_i[n]) begin
                            w_stretch = c_str_load;
                        end else if (w_tick && (r_stretch != '0)) begin
                            w_stretch = r_stretch - c_str_w'(1);
                        end
                        if (r_mode == MODE_LINK_ACT) begin
                            // Flicker phase only runs while stretch is live.
                            if (w_stretch == '0) begin
                                w_pcnt  = '0;
                                w_phase = 1'b0;
                            end else if (w_tick && (r_stretch != '0)) begin
                                if (32'(r_pcnt) + 32'd1 >= c_act_half) begin
                                    w_pcnt  = '0;
                                    w_phase = ~r_phase;
                                end else begin
                                    w_pcnt = r_pcnt + c_pcnt_w'(1);
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end

            // The LED is decoded from next-state values so the register
            // reflects an input change exactly one cycle later.
            case (w_mode)
                MODE_ON:       w_led = 1'b1;
                MODE_BLINK:    w_led = w_phase;
                MODE_ACTIVITY: w_led = (w_stretch != '0);
                MODE_LINK_ACT: w_led = link_i[n] & ((w_stretch == '0) | ~w_phase);
                default:       w_led = 1'b0;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_mode    <= MODE_OFF;
                r_pcnt    <= '0;
                r_phase   <= 1'b0;
                r_stretch <= '0;
                r_led     <= ACTIVE_LOW;
            end else begin
                r_mode    <= w_mode;
                r_pcnt    <= w_pcnt;
                r_phase   <= w_phase;
                r_stretch <= w_stretch;
                r_led     <= w_led ^ ACTIVE_LOW;
            end
        end

        assign led_o[n] = r_led;
    end

endmodule
`default_nettype wire
